// File: rtl/sim_run_ctrl.sv
// Run controller for the CPU bench: sequences the core reset, counts RUN cycles
// and retired writes, and ends the run on a PC self-loop (halt) or a cycle budget.
module sim_run_ctrl #(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 10,
    parameter int STALL_LIMIT  = 8,
    parameter int MAX_CYCLES   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             wb_en,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [2:0]       dbg_state
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int RL_W   = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [RL_W-1:0]   STALL_C   = RL_W'(STALL_LIMIT);
    localparam logic [RL_W-1:0]   RL_ONE    = RL_W'(1);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RESET_HOLD = 3'd1,
        S_RUN        = 3'd2,
        S_DONE       = 3'd3,
        S_TIMEOUT    = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_cpu_reset;
    logic              r_running;
    logic              r_done;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_retire_count;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [RL_W-1:0]   r_run_len;
    logic [PC_W-1:0]   r_last_pc;
    logic              r_last_valid;

    logic              w_pc_same;
    logic [RL_W-1:0]   w_run_len_next;
    logic [CNT_W-1:0]  w_cycle_next;
    logic [CNT_W-1:0]  w_retire_next;
    logic              w_halt;
    logic              w_budget_out;

    // run_len never exceeds STALL_LIMIT-1 while in RUN, so the increment cannot wrap.
    assign w_pc_same      = r_last_valid && (pc == r_last_pc);
    assign w_run_len_next = w_pc_same ? (r_run_len + RL_ONE) : RL_ONE;
    assign w_cycle_next   = r_cycle_count + CNT_ONE;
    assign w_retire_next  = r_retire_count + {{(CNT_W-1){1'b0}}, wb_en};
    assign w_halt         = (w_run_len_next == STALL_C);
    assign w_budget_out   = (w_cycle_next == MAX_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cpu_reset    <= 1'b1;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
            r_hold_cnt     <= '0;
            r_run_len      <= '0;
            r_last_pc      <= '0;
            r_last_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_reset <= 1'b1;
                    if (start) begin
                        r_state        <= S_RESET_HOLD;
                        r_cycle_count  <= '0;
                        r_retire_count <= '0;
                        r_hold_cnt     <= '0;
                        r_run_len      <= '0;
                        r_last_valid   <= 1'b0;
                    end
                end
                S_RESET_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // The edge that ends the run still applies its counter updates.
                    r_cycle_count  <= w_cycle_next;
                    r_retire_count <= w_retire_next;
                    r_run_len      <= w_run_len_next;
                    r_last_pc      <= pc;
                    r_last_valid   <= 1'b1;
                    if (w_halt) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_budget_out) begin
                        r_state   <= S_TIMEOUT;
                        r_running <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        r_state        <= S_RESET_HOLD;
                        r_cpu_reset    <= 1'b1;
                        r_done         <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_cycle_count  <= '0;
                        r_retire_count <= '0;
                        r_hold_cnt     <= '0;
                        r_run_len      <= '0;
                        r_last_valid   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cpu_reset <= 1'b1;
                    r_running   <= 1'b0;
                    r_done      <= 1'b0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_reset    = r_cpu_reset;
    assign running      = r_running;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign cycle_count  = r_cycle_count;
    assign retire_count = r_retire_count;
    assign dbg_state    = r_state;

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesisable run controller that replaces the free-running clock-and-reset stimulus of the CPU bench.
- Sequences the CPU reset pulse for a parametrised number of cycles.
- Counts executed cycles and retired register writes.
- Ends the run on halt detection: the PC holds one value for a programmable number of consecutive cycles (the self-branch end-of-program idiom). Ends it on a cycle-budget timeout otherwise.
- Sits between the top-level bench and the `mips` core. Drives the core's reset. Observes the core's PC and writeback enable.

Parameters:
- PC_W, 32, width of the observed PC.
- CNT_W, 32, width of the cycle and retire counters.
- RESET_CYCLES, 10, number of cycles cpu_reset is held after a start; must be >= 1.
- STALL_LIMIT, 8, number of consecutive identical PC samples that means halt; must be >= 2.
- MAX_CYCLES, 100000, RUN-cycle budget before timeout; must be >= 1 and < 2^CNT_W.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high; returns the block to IDLE.
- start, in, 1, level; sampled only in IDLE, DONE and TIMEOUT.
- pc, in, PC_W, current fetch PC of the core.
- wb_en, in, 1, core register-file write enable (one retire per high cycle).
- cpu_reset, out, 1, reset driven into the core.
- running, out, 1, high in RUN.
- done, out, 1, high in DONE (halt detected).
- timeout, out, 1, high in TIMEOUT.
- cycle_count, out, CNT_W, RUN cycles elapsed.
- retire_count, out, CNT_W, wb_en-high cycles during RUN.

Behaviour:
- States: IDLE, RESET_HOLD, RUN, DONE, TIMEOUT. All outputs are registered.
- Reset (reset=1 at an edge, any state, including mid-RUN):
  - State goes to IDLE.
  - cpu_reset=1; running=done=timeout=0.
  - cycle_count=retire_count=0.
  - Hold counter, run-length counter and last_pc are cleared.
  - reset has priority over start.
- IDLE: cpu_reset=1. start=1 at edge k moves to RESET_HOLD and clears both counters.
- RESET_HOLD:
  - cpu_reset=1; the hold counter increments each cycle.
  - At edge k+RESET_CYCLES the state moves to RUN with cpu_reset=0 and running=1.
  - The core therefore sees exactly RESET_CYCLES rising edges with cpu_reset high after start, plus any preceding IDLE cycles.
  - start is ignored.
- RUN, at each edge:
  - cycle_count += 1.
  - retire_count += wb_en.
  - Run-length: if a previous sample is valid and pc == last_pc, run_len += 1; otherwise run_len = 1. Then last_pc <= pc and the sample becomes valid. The first RUN sample always gives run_len = 1.
  - Halt: if the updated run_len == STALL_LIMIT, go to DONE.
  - Timeout: else if the updated cycle_count == MAX_CYCLES, go to TIMEOUT.
  - Halt wins when both occur on the same edge.
  - start is ignored.
- DONE and TIMEOUT:
  - cpu_reset=0; the core is not disturbed.
  - Counters are frozen; done or timeout is held.
  - start=1 goes to RESET_HOLD, clears the counters and run-length state, and sets cpu_reset=1 on that edge.
- The transitioning edge still counts: the edge that enters DONE/TIMEOUT also applies its cycle_count and retire_count increments.
- Counters never wrap. Their terminal value is bounded by MAX_CYCLES (< 2^CNT_W).
- Multiple wb_en pulses are counted one per cycle. No deduplication.

Test Plan:
- Parameters for all scenarios unless stated: RESET_CYCLES=4, STALL_LIMIT=3, MAX_CYCLES=20.
- Reset/start sequencing: assert reset 2 cycles, then start=1 for 1 cycle at edge 3 -> cpu_reset=1 through edge 6, cpu_reset=0 and running=1 from edge 7. cycle_count=0 at edge 7.
- Halt detect: in RUN, drive pc 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 with wb_en=1,0,1,1,0 -> DONE after the 5th RUN edge. cycle_count=5, retire_count=3, done=1, running=0.
- Near-halt reset of run length: pc 0x3000, 0x3000, 0x3004, 0x3004, 0x3008 then incrementing -> no DONE. With pc always distinct, timeout=1 after the 20th RUN edge with cycle_count=20.
- Halt/timeout collision: MAX_CYCLES=3, STALL_LIMIT=3, pc constant 0x3000 -> DONE (not TIMEOUT) with cycle_count=3.
- Reset mid-RUN: reset at RUN cycle 6 -> next edge IDLE, cpu_reset=1, all counts 0. start ignored while reset=1.
- Restart: from DONE, pulse start -> cpu_reset=1 for 4 edges, counters 0, done=0. A second run with pc constant halts at cycle_count=3. start pulses during RESET_HOLD/RUN have no effect.
